// File: rtl/lcd_pkg.sv
// Shared definitions for the LCD instruction sequencer: FSM encoding,
// instruction word layout and the clear/home detection helper.
package lcd_pkg;

    // Instruction word layout: [10:3] byte, [2] unused, [1] RW, [0] RS
    localparam int INSTR_W = 11;
    localparam int BYTE_HI = 10;
    localparam int BYTE_LO = 3;
    localparam int RW_BIT  = 1;
    localparam int RS_BIT  = 0;

    // Bytes at or below this value with RS=0 are clear/home instructions,
    // which need the long post-instruction wait.
    localparam logic [7:0] CLR_HOME_MAX = 8'h03;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETUP  = 3'd1,
        ST_PULSE  = 3'd2,
        ST_WAIT   = 3'd3,
        ST_FINISH = 3'd4
    } lcd_state_t;

    function automatic logic [7:0] instr_byte(input logic [INSTR_W-1:0] w);
        return w[BYTE_HI:BYTE_LO];
    endfunction

    function automatic logic is_clr_home(input logic [7:0] b, input logic rs);
        return (rs == 1'b0) && (b <= CLR_HOME_MAX);
    endfunction

endpackage

// File: rtl/lcd_instr_buf.sv
// Instruction register file: one synchronous write port, one
// asynchronous read port. Storage has no reset; the owner's count
// decides which entries are meaningful.
module lcd_instr_buf
    import lcd_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_idx,
    input  logic [INSTR_W-1:0]       wr_data,
    input  logic [$clog2(DEPTH)-1:0] rd_idx,
    output logic [INSTR_W-1:0]       rd_data
);

    logic [INSTR_W-1:0] mem [DEPTH];

    // Write port
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_idx] <= wr_data;
        end
    end

    assign rd_data = mem[rd_idx];

endmodule

// File: rtl/lcd_cmd_seq.sv
// LCD command sequencer: buffers HD44780-style instructions and plays
// them back with setup / enable / post-wait timing, in 8-bit or 4-bit
// bus mode. One shared down-counter times every phase.
module lcd_cmd_seq
    import lcd_pkg::*;
#(
    parameter int DEPTH        = 16,
    parameter int SETUP_CYCLES = 4,
    parameter int EN_CYCLES    = 24,
    parameter int CMD_WAIT     = 2000,
    parameter int CLR_WAIT     = 82000,
    parameter int NIBBLE_MODE  = 0
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   wr_en,
    input  logic [INSTR_W-1:0]     wr_data,
    input  logic                   flush,
    input  logic                   init,
    output logic                   busy,
    output logic                   full,
    output logic [$clog2(DEPTH):0] count,
    output logic                   DONE,
    output logic                   lcd_rs,
    output logic                   lcd_rw,
    output logic                   lcd_e,
    output logic [7:0]             lcd_data,
    output logic [INSTR_W-1:0]     salida
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = IDX_W + 1;

    // Timer sized for the longest phase
    localparam int MAX_A = (SETUP_CYCLES > EN_CYCLES) ? SETUP_CYCLES : EN_CYCLES;
    localparam int MAX_B = (CMD_WAIT > CLR_WAIT) ? CMD_WAIT : CLR_WAIT;
    localparam int MAX_T = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int TW    = $clog2(MAX_T + 1);

    localparam logic [TW-1:0] SETUP_LD = TW'(SETUP_CYCLES - 1);
    localparam logic [TW-1:0] EN_LD    = TW'(EN_CYCLES - 1);
    localparam logic [TW-1:0] CMD_LD   = TW'(CMD_WAIT - 1);
    localparam logic [TW-1:0] CLR_LD   = TW'(CLR_WAIT - 1);

    lcd_state_t          state;
    logic [TW-1:0]       timer;
    logic [IDX_W-1:0]    rd_idx;
    logic [7:0]          cur_byte;
    logic                cur_long;
    logic                low_half;

    logic                idle;
    logic                wr_accept;
    logic [CNT_W-1:0]    count_nxt;
    logic [IDX_W-1:0]    rd_addr;
    logic [INSTR_W-1:0]  rd_word;
    logic [INSTR_W-1:0]  ld_word;
    logic [7:0]          ld_byte;
    logic                last_entry;
    logic                unused_bit;

    assign idle      = (state == ST_IDLE);
    assign wr_accept = idle && wr_en && !full && !flush;
    assign full      = (count == CNT_W'(DEPTH));

    // Buffer occupancy after this edge; flush beats a simultaneous write
    always_comb begin
        count_nxt = count;
        if (idle && flush) begin
            count_nxt = '0;
        end else if (wr_accept) begin
            count_nxt = count + 1'b1;
        end
    end

    // Occupancy register
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else begin
            count <= count_nxt;
        end
    end

    // In IDLE we prefetch entry 0; during playback the entry after rd_idx
    assign rd_addr = idle ? '0 : rd_idx + 1'b1;

    lcd_instr_buf #(
        .DEPTH (DEPTH)
    ) u_buf (
        .clk     (clk),
        .wr_en   (wr_accept && !reset),
        .wr_idx  (count[IDX_W-1:0]),
        .wr_data (wr_data),
        .rd_idx  (rd_addr),
        .rd_data (rd_word)
    );

    // A write landing in entry 0 on the init edge is not in storage yet,
    // so forward it straight to the bus.
    assign ld_word    = (idle && wr_accept && (count == '0)) ? wr_data : rd_word;
    assign ld_byte    = instr_byte(ld_word);
    assign last_entry = ((CNT_W'(rd_idx) + 1'b1) == count);
    assign unused_bit = ld_word[2];

    assign salida = {lcd_data, lcd_e, lcd_rw, lcd_rs};

    // Playback FSM with registered LCD outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_IDLE;
            timer    <= '0;
            rd_idx   <= '0;
            cur_byte <= '0;
            cur_long <= 1'b0;
            low_half <= 1'b0;
            busy     <= 1'b0;
            DONE     <= 1'b0;
            lcd_e    <= 1'b0;
            lcd_rs   <= 1'b0;
            lcd_rw   <= 1'b0;
            lcd_data <= '0;
        end else begin
            DONE <= 1'b0;
            case (state)
                ST_IDLE: begin
                    lcd_e <= 1'b0;
                    if (init) begin
                        if (count_nxt == '0) begin
                            state <= ST_FINISH;
                            DONE  <= 1'b1;
                        end else begin
                            state    <= ST_SETUP;
                            busy     <= 1'b1;
                            rd_idx   <= '0;
                            timer    <= SETUP_LD;
                            low_half <= 1'b0;
                            cur_byte <= ld_byte;
                            cur_long <= is_clr_home(ld_byte, ld_word[RS_BIT]);
                            lcd_rs   <= ld_word[RS_BIT];
                            lcd_rw   <= ld_word[RW_BIT];
                            lcd_data <= (NIBBLE_MODE != 0) ? {ld_byte[7:4], 4'h0} : ld_byte;
                        end
                    end
                end

                ST_SETUP: begin
                    if (timer == '0) begin
                        state <= ST_PULSE;
                        lcd_e <= 1'b1;
                        timer <= EN_LD;
                    end else begin
                        timer <= timer - 1'b1;
                    end
                end

                ST_PULSE: begin
                    if (timer == '0) begin
                        lcd_e <= 1'b0;
                        if ((NIBBLE_MODE != 0) && !low_half) begin
                            // Second transfer carries the low nibble
                            state    <= ST_SETUP;
                            low_half <= 1'b1;
                            lcd_data <= {cur_byte[3:0], 4'h0};
                            timer    <= SETUP_LD;
                        end else begin
                            state <= ST_WAIT;
                            timer <= cur_long ? CLR_LD : CMD_LD;
                        end
                    end else begin
                        timer <= timer - 1'b1;
                    end
                end

                ST_WAIT: begin
                    if (timer == '0) begin
                        if (last_entry) begin
                            state <= ST_FINISH;
                            busy  <= 1'b0;
                            DONE  <= 1'b1;
                        end else begin
                            state    <= ST_SETUP;
                            rd_idx   <= rd_idx + 1'b1;
                            timer    <= SETUP_LD;
                            low_half <= 1'b0;
                            cur_byte <= ld_byte;
                            cur_long <= is_clr_home(ld_byte, ld_word[RS_BIT]);
                            lcd_rs   <= ld_word[RS_BIT];
                            lcd_rw   <= ld_word[RW_BIT];
                            lcd_data <= (NIBBLE_MODE != 0) ? {ld_byte[7:4], 4'h0} : ld_byte;
                        end
                    end else begin
                        timer <= timer - 1'b1;
                    end
                end

                ST_FINISH: begin
                    state  <= ST_IDLE;
                    rd_idx <= '0;
                    busy   <= 1'b0;
                end

                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                    lcd_e <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/lcd_cmd_seq.md
LCD_CMD_SEQ -- requirements
Module: lcd_cmd_seq

Interface
REQ-001 Parameter DEPTH, default 16: instruction buffer entries; power of two, minimum 2.
REQ-002 Parameter SETUP_CYCLES, default 4: cycles from RS/RW/data driven to E rising.
REQ-003 Parameter EN_CYCLES, default 24: E high width in cycles.
REQ-004 Parameter CMD_WAIT, default 2000: post-instruction wait in cycles for normal instructions.
REQ-005 Parameter CLR_WAIT, default 82000: post-instruction wait in cycles for clear/home instructions.
REQ-006 Parameter NIBBLE_MODE, default 0: 0 selects an 8-bit bus; 1 selects a 4-bit bus (two E pulses per instruction).
REQ-007 clk  in  1  single system clock; all logic on its rising edge.
REQ-008 reset  in  1  synchronous, active-high reset.
REQ-009 wr_en  in  1  write one instruction into the buffer.
REQ-010 wr_data  in  11  instruction word: [10:3] byte, [2] ignored, [1] RW, [0] RS.
REQ-011 flush  in  1  empty the buffer (count to 0).
REQ-012 init  in  1  start playback of all buffered instructions.
REQ-013 busy  out  1  high while playback is in progress.
REQ-014 full  out  1  high when count equals DEPTH.
REQ-015 count  out  $clog2(DEPTH)+1  number of buffered instructions.
REQ-016 DONE  out  1  one-cycle pulse when playback finishes.
REQ-017 lcd_rs, lcd_rw, lcd_e  out  1 each  LCD control lines.
REQ-018 lcd_data  out  8  LCD data bus; in nibble mode only [7:4] carry data and [3:0] are driven 0.
REQ-019 salida  out  11  status mirror {lcd_data, lcd_e, lcd_rw, lcd_rs}.

Function
REQ-020 Buffer writes take effect only in IDLE with full low; writes while busy or full are dropped, and count is unchanged.
REQ-021 Writes go to index count, and count increments on the next edge.
REQ-022 Buffer contents persist after playback, so a repeated init replays the same sequence.
REQ-023 flush is honoured only in IDLE and has priority over a simultaneous wr_en.
REQ-024 Playback FSM states: IDLE, SETUP, PULSE, WAIT, FINISH.
REQ-025 init in IDLE with count>0 sets busy and loads entry 0 on the next edge; lcd_rs, lcd_rw and lcd_data are valid in that same cycle.
REQ-026 SETUP lasts SETUP_CYCLES cycles with E low.
REQ-027 PULSE lasts EN_CYCLES cycles with E high.
REQ-028 WAIT lasts CLR_WAIT cycles when RS=0 and byte<=0x03; otherwise it lasts CMD_WAIT cycles.
REQ-029 A simultaneous init and wr_en in IDLE: the write is accepted, and playback uses the updated count.
REQ-030 In nibble mode, the FSM runs SETUP/PULSE for the high nibble, then SETUP/PULSE for the low nibble, then a single WAIT.
REQ-031 After the WAIT of entry count-1, the FSM enters FINISH: DONE is high for one cycle, busy falls, and the next state is IDLE.
REQ-032 Otherwise the read index increments, and the FSM returns to SETUP with the next entry driven.
REQ-033 init in IDLE with count==0 produces a DONE pulse on the next cycle with no E activity.
REQ-034 init while busy is ignored.
REQ-035 In IDLE, lcd_e is 0; lcd_rs, lcd_rw and lcd_data hold their last driven values.
REQ-036 Per-instruction latency in 8-bit mode is SETUP_CYCLES+EN_CYCLES+wait cycles.

Reset
REQ-037 While reset is high at a rising edge, the FSM goes to IDLE and count, read index, busy, DONE, lcd_e, lcd_rs, lcd_rw, lcd_data and salida are all 0.
REQ-038 Reset asserted mid-playback forces E low at that edge; no partial pulse may resume.
REQ-039 Buffer storage is not cleared by reset; it is unreachable because count is 0.

Structure
REQ-040 Package lcd_pkg holds the FSM state encoding, the instruction field positions (byte, RW, RS) and the clear/home threshold 0x03.
REQ-041 Sub-module lcd_instr_buf holds the DEPTH x 11 register file with write port and asynchronous read index.
REQ-042 One shared down-counter, sized for max(SETUP_CYCLES, EN_CYCLES, CMD_WAIT, CLR_WAIT), times all phases.

Verification (bench parameters SETUP=2, EN=3, CMD_WAIT=10, CLR_WAIT=40, DEPTH=16)
REQ-043 Write 0x00C (clear), then init -> E high for exactly 3 cycles starting 3 cycles after init; DONE pulses 46 cycles after init.
REQ-044 Write the 10-word sequence 0x00C, 0x014, 0x07C, 0x21D, 0x295, 0x24D, 0x29D, 0x2A5, 0x24D, 0x20D, then init -> 10 E pulses; bytes 01, 02, 0F, then "CRISTIA" with RS=1 on the data words; DONE 211 cycles after init.
REQ-045 Write 16 words, then a 17th -> full=1, count=16, 17th dropped; flush -> count=0; init -> DONE next cycle, lcd_e stays 0.
REQ-046 NIBBLE_MODE=1, write 0x21D -> lcd_data[7:4]=4 on the first pulse and 3 on the second, 2 E pulses, DONE 21 cycles after init.
REQ-047 Reset asserted during the second PULSE of a 3-word playback -> E low next edge, busy=0, count=0, no DONE pulse.
REQ-048 init during WAIT, and wr_en while busy -> neither affects the sequence or count; replay after DONE reproduces identical output.
